// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : op-codes, default op width and FSM encoding for muldiv_req
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_MUL    = 4'd0;
  localparam logic [OPW-1:0] OP_MULH   = 4'd1;
  localparam logic [OPW-1:0] OP_MULHSU = 4'd2;
  localparam logic [OPW-1:0] OP_MULHU  = 4'd3;
  localparam logic [OPW-1:0] OP_DIV    = 4'd4;
  localparam logic [OPW-1:0] OP_DIVU   = 4'd5;
  localparam logic [OPW-1:0] OP_REM    = 4'd6;
  localparam logic [OPW-1:0] OP_REMU   = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_req_if.sv
// ============================================================================
// muldiv_req_if : request/response link between muldiv_req and the MULDIV unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface muldiv_req_if #(
  parameter int XLEN = 64,
  parameter int OPW  = muldiv_pkg::OPW
);

  logic            md_en;
  logic [OPW-1:0]  md_op;
  logic [XLEN-1:0] md_rs1;
  logic [XLEN-1:0] md_rs2;
  logic            md_ready;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  modport master (
    output md_en, md_op, md_rs1, md_rs2,
    input  md_ready, md_valid, md_result
  );

  modport slave (
    input  md_en, md_op, md_rs1, md_rs2,
    output md_ready, md_valid, md_result
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_div0_fix.sv
// ============================================================================
// muldiv_div0_fix : divide-by-zero result generator (MULDIV_DIV0_BYPASS_EN)
// Revision        : 1.0
// ============================================================================
`default_nettype none

`ifdef MULDIV_DIV0_BYPASS_EN
module muldiv_div0_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = muldiv_pkg::OPW
) (
  input  wire logic [OPW-1:0]  op_i,
  input  wire logic [XLEN-1:0] rs1_i,
  output logic                 is_div_o,
  output logic [XLEN-1:0]      result_o
);

  logic w_is_quot;
  logic w_is_rem;

  assign w_is_quot = (op_i == OPW'(OP_DIV)) || (op_i == OPW'(OP_DIVU));
  assign w_is_rem  = (op_i == OPW'(OP_REM)) || (op_i == OPW'(OP_REMU));
  assign is_div_o  = w_is_quot | w_is_rem;

  // Quotient by zero is all-ones; remainder by zero is the dividend.
  assign result_o  = w_is_quot ? {XLEN{1'b1}} : rs1_i;

endmodule
`endif

`default_nettype wire

// File: rtl/muldiv_req.sv
// ============================================================================
// muldiv_req : EX-stage request sequencer for an external MULDIV unit.
//              Optional div-by-zero bypass under MULDIV_DIV0_BYPASS_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module muldiv_req
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = muldiv_pkg::OPW
) (
  input  wire logic            clk,
  input  wire logic            rst,

  input  wire logic            req_valid_i,
  input  wire logic [OPW-1:0]  req_op_i,
  input  wire logic [XLEN-1:0] req_rs1_i,
  input  wire logic [XLEN-1:0] req_rs2_i,
  input  wire logic [4:0]      req_rd_i,
  input  wire logic            flush_i,
  output logic                 stall_o,

  muldiv_req_if.master         md,

  output logic                 wb_valid_o,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o
);

  md_state_e       state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [4:0]      rd_q;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_load;

  logic            w_md_en;
  logic            w_accept;
  logic            w_bypass;
  logic            w_complete;
  logic [XLEN-1:0] w_div0_result;

  assign w_md_en    = (state_q == BUSY) || (state_q == DRAIN);
  assign w_accept   = (state_q == IDLE) && req_valid_i && !flush_i;
  assign w_complete = w_md_en && md.md_ready && md.md_valid;

`ifdef MULDIV_DIV0_BYPASS_EN
  logic w_is_div;

  muldiv_div0_fix #(
    .XLEN (XLEN),
    .OPW  (OPW)
  ) u_div0_fix (
    .op_i     (req_op_i),
    .rs1_i    (req_rs1_i),
    .is_div_o (w_is_div),
    .result_o (w_div0_result)
  );

  assign w_bypass = w_accept && w_is_div && (req_rs2_i == '0);
`else
  assign w_bypass      = 1'b0;
  assign w_div0_result = '0;
`endif

  always_comb begin
    state_d   = state_q;
    wb_load   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (w_bypass) begin
          state_d   = DONE;
          wb_load   = 1'b1;
          wb_rd_d   = req_rd_i;
          wb_data_d = w_div0_result;
        end else if (w_accept) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A flush always beats a same-cycle completion; the result is dropped.
        if (flush_i) begin
          state_d = w_complete ? IDLE : DRAIN;
        end else if (w_complete) begin
          state_d   = DONE;
          wb_load   = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = md.md_result;
        end
      end
      DRAIN: begin
        if (w_complete) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept && !w_bypass) begin
        op_q  <= req_op_i;
        rs1_q <= req_rs1_i;
        rs2_q <= req_rs2_i;
        rd_q  <= req_rd_i;
      end
      if (wb_load) begin
        wb_rd_q   <= wb_rd_d;
        wb_data_q <= wb_data_d;
      end
    end
  end

  assign md.md_en  = w_md_en;
  assign md.md_op  = op_q;
  assign md.md_rs1 = rs1_q;
  assign md.md_rs2 = rs2_q;

  assign stall_o    = ((state_q == IDLE) && req_valid_i) || w_md_en;
  assign wb_valid_o = (state_q == DONE) && !flush_i;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

`default_nettype wire

// File: doc/muldiv_req.md
MULDIV_REQ -- requirements
Module: muldiv_req

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 Parameter OPW, default 4, op-code width (codes in muldiv_pkg).
REQ-003 clk  in  1  clock; reset rst, synchronous, active-low.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 req_valid_i  in  1  EX holds a mul/div instruction; held stable until stall_o low.
REQ-006 req_op_i  in  OPW  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
REQ-007 req_rs1_i, req_rs2_i  in  XLEN each  source operands.
REQ-008 req_rd_i  in  5  destination register.
REQ-009 flush_i  in  1  pipeline flush; kills the in-flight request.
REQ-010 stall_o  out  1  freeze upstream stages.
REQ-011 md_en_o  out  1  request to the MULDIV unit.
REQ-012 md_op_o  out  OPW, md_rs1_o, md_rs2_o  out  XLEN  latched request.
REQ-013 md_ready_i, md_valid_i  in  1 each; md_result_i  in  XLEN  unit response.
REQ-014 wb_valid_o  out  1, wb_rd_o  out  5, wb_data_o  out  XLEN  write-back.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DRAIN, DONE.
REQ-016 IDLE: req_valid_i & !flush_i SHALL latch op/rs1/rs2/rd and enter BUSY next cycle.
REQ-017 md_en_o SHALL be 1 exactly in BUSY and DRAIN; md_op/rs1/rs2_o SHALL be stable throughout.
REQ-018 Completion SHALL be md_en_o & md_ready_i & md_valid_i sampled at a clk edge.
REQ-019 BUSY: completion & !flush_i SHALL capture md_result_i into wb_data_o and enter DONE.
REQ-020 BUSY: flush_i SHALL enter DRAIN (or IDLE if completion in that same cycle); flush wins over completion.
REQ-021 DRAIN: completion SHALL discard the result and enter IDLE; flush_i ignored.
REQ-022 DONE: wb_valid_o=1 for exactly one cycle unless flush_i, then wb_valid_o=0; always next state IDLE.
REQ-023 stall_o SHALL be (IDLE & req_valid_i) | BUSY | DRAIN, combinational; 0 in DONE.
REQ-024 req_valid_i in DONE SHALL be ignored (still the retiring instruction).
REQ-025 Minimum latency: request seen in IDLE -> wb_valid_o 2 cycles later when unit completes first BUSY cycle.
REQ-026 wb_rd_o, wb_data_o SHALL hold last value outside DONE.

Reset
REQ-027 rst=0 at a clk edge SHALL force IDLE; all outputs 0 (stall_o follows REQ-023).
REQ-028 Reset mid-BUSY/DRAIN SHALL drop md_en_o the next cycle; no write-back.

Configuration
REQ-029 Macro MULDIV_DIV0_BYPASS_EN defined: DIV/DIVU/REM/REMU with rs2==0 in IDLE SHALL skip MULDIV, go IDLE->DONE directly; result all-ones for DIV/DIVU, rs1 for REM/REMU; md_en_o stays 0.
REQ-030 Macro undefined: every request SHALL issue to MULDIV per REQ-016.

Structure
REQ-031 muldiv_pkg SHALL hold op-code constants, OPW, FSM state encoding.
REQ-032 Optional sub-module muldiv_div0_fix (div-by-zero result generator) under the macro; otherwise single module.

Verification
REQ-033 MUL rs1=3 rs2=5 rd=7, unit completes 1st BUSY cycle -> wb_valid_o pulse, wb_rd_o=7, wb_data_o=unit result; stall_o 1 for 2 cycles.
REQ-034 Unit ready/valid held 0 for 10 BUSY cycles -> md_en_o and operands stable 10 cycles, stall_o 1 throughout, single wb pulse.
REQ-035 flush_i in 2nd BUSY cycle, unit completes 3 cycles later -> DRAIN, wb_valid_o never 1, IDLE after completion.
REQ-036 With macro: DIVU rs1=9 rs2=0 -> md_en_o never 1, wb_data_o=all-ones next cycle; REM rs1=9 rs2=0 -> 9.
REQ-037 rst=0 during BUSY -> next cycle IDLE, md_en_o=0, wb_valid_o=0, stall_o=req_valid_i.
REQ-038 Back-to-back MUL then DIVU -> two wb pulses, second request sampled only in IDLE after DONE.
